// File: rtl/lighthouse_ootx_decoder.sv
// OOTX frame decoder: preamble hunt, stuff-bit framing, length/payload extraction, CRC32 check.
// Optional macro LIGHTHOUSE_OOTX_CRC_EN builds the CRC32 datapath; otherwise crc_ok reads 1.
module lighthouse_ootx_decoder #(
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned PREAMBLE = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_strobe,
  input  logic        bit_value,
  output logic [7:0]  data,
  output logic        data_strobe,
  output logic [15:0] length,
  output logic        frame_start,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        error
);

  localparam int unsigned ZW = $clog2(PREAMBLE + 1);
  localparam logic [ZW-1:0] PRE_CNT   = ZW'(PREAMBLE);
  localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [1:0] {StHunt, StLen, StPayload, StCrc} state_e;

  state_e        state_q, state_d;
  logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [15:0]   word_q, word_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic          crc_half_q, crc_half_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   length_q, length_d;
  logic          data_strobe_q, data_strobe_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_done_q, frame_done_d;
  logic          crc_ok_q, crc_ok_d;
  logic          error_q, error_d;

  logic [15:0]   new_word;
  logic [7:0]    byte_val;
  logic [15:0]   len_field;

  assign new_word  = {word_q[14:0], bit_value};
  assign byte_val  = {word_q[6:0], bit_value};
  // Length field is little-endian: byte A (first received, bits 15:8) is the low byte.
  assign len_field = {word_q[7:0], word_q[15:8]};

`ifdef LIGHTHOUSE_OOTX_CRC_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_rx_q, crc_rx_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d       = state_q;
    zero_cnt_d    = zero_cnt_q;
    bit_idx_d     = bit_idx_q;
    word_d        = word_q;
    byte_cnt_d    = byte_cnt_q;
    crc_half_d    = crc_half_q;
    data_d        = data_q;
    length_d      = length_q;
    crc_ok_d      = crc_ok_q;
    data_strobe_d = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    error_d       = 1'b0;
`ifdef LIGHTHOUSE_OOTX_CRC_EN
    crc_d         = crc_q;
    crc_rx_d      = crc_rx_q;
`endif
    if (bit_strobe) begin
      if (state_q == StHunt) begin
        if (!bit_value) begin
          if (zero_cnt_q < PRE_CNT) zero_cnt_d = zero_cnt_q + 1'b1;
        end else if (zero_cnt_q >= PRE_CNT) begin
          state_d    = StLen;
          bit_idx_d  = '0;
          zero_cnt_d = '0;
        end else begin
          zero_cnt_d = '0;
        end
      end else if (bit_idx_q == 5'd16) begin
        bit_idx_d = '0;
        if (!bit_value) begin
          // A bad stuff bit is a zero and may start the next preamble.
          error_d    = 1'b1;
          state_d    = StHunt;
          zero_cnt_d = ZW'(1);
        end else begin
          unique case (state_q)
            StLen: begin
              if (len_field > MAX_LEN_W) begin
                error_d    = 1'b1;
                state_d    = StHunt;
                zero_cnt_d = '0;
              end else begin
                frame_start_d = 1'b1;
                length_d      = len_field;
                crc_ok_d      = 1'b0;
                byte_cnt_d    = '0;
                crc_half_d    = 1'b0;
                state_d       = (len_field == 16'd0) ? StCrc : StPayload;
`ifdef LIGHTHOUSE_OOTX_CRC_EN
                crc_d         = 32'hFFFFFFFF;
`endif
              end
            end
            StPayload: begin
              if (byte_cnt_q == length_q) begin
                state_d    = StCrc;
                crc_half_d = 1'b0;
              end
            end
            StCrc: begin
              if (crc_half_q) begin
                frame_done_d = 1'b1;
                state_d      = StHunt;
                zero_cnt_d   = '0;
`ifdef LIGHTHOUSE_OOTX_CRC_EN
                crc_ok_d     = (crc_rx_q == ~crc_q);
`else
                crc_ok_d     = 1'b1;
`endif
              end else begin
                crc_half_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end else begin
        word_d    = new_word;
        bit_idx_d = bit_idx_q + 5'd1;
        if (bit_idx_q == 5'd7 || bit_idx_q == 5'd15) begin
          // Pad byte of an odd-length payload is neither streamed nor hashed.
          if (state_q == StPayload && byte_cnt_q < length_q) begin
            data_d        = byte_val;
            data_strobe_d = 1'b1;
            byte_cnt_d    = byte_cnt_q + 16'd1;
`ifdef LIGHTHOUSE_OOTX_CRC_EN
            crc_d         = crc32_byte(crc_q, byte_val);
`endif
          end
`ifdef LIGHTHOUSE_OOTX_CRC_EN
          if (state_q == StCrc) crc_rx_d = {byte_val, crc_rx_q[31:8]};
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StHunt;
      zero_cnt_q    <= '0;
      bit_idx_q     <= '0;
      word_q        <= '0;
      byte_cnt_q    <= '0;
      crc_half_q    <= 1'b0;
      data_q        <= '0;
      length_q      <= '0;
      data_strobe_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      crc_ok_q      <= 1'b0;
      error_q       <= 1'b0;
`ifdef LIGHTHOUSE_OOTX_CRC_EN
      crc_q         <= '0;
      crc_rx_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      zero_cnt_q    <= zero_cnt_d;
      bit_idx_q     <= bit_idx_d;
      word_q        <= word_d;
      byte_cnt_q    <= byte_cnt_d;
      crc_half_q    <= crc_half_d;
      data_q        <= data_d;
      length_q      <= length_d;
      data_strobe_q <= data_strobe_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      crc_ok_q      <= crc_ok_d;
      error_q       <= error_d;
`ifdef LIGHTHOUSE_OOTX_CRC_EN
      crc_q         <= crc_d;
      crc_rx_q      <= crc_rx_d;
`endif
    end
  end

  assign data        = data_q;
  assign data_strobe = data_strobe_q;
  assign length      = length_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign crc_ok      = crc_ok_q;
  assign error       = error_q;

endmodule

// File: tb/tb_lighthouse_ootx_decoder.sv
// Scoreboard bench for lighthouse_ootx_decoder: directed OOTX frames, expected pulses queued.
module tb_lighthouse_ootx_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_strobe;
  logic        bit_value;
  logic [7:0]  data;
  logic        data_strobe;
  logic [15:0] length;
  logic        frame_start;
  logic        frame_done;
  logic        crc_ok;
  logic        error;

  lighthouse_ootx_decoder #(.MAX_LEN(64), .PREAMBLE(17)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_strobe (bit_strobe),
    .bit_value  (bit_value),
    .data       (data),
    .data_strobe(data_strobe),
    .length     (length),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .error      (error)
  );

  always #10 clk = ~clk;

  localparam int EvData = 0, EvStart = 1, EvDone = 2, EvErr = 3;
`ifdef LIGHTHOUSE_OOTX_CRC_EN
  localparam logic BadCrcOk = 1'b0;
`else
  localparam logic BadCrcOk = 1'b1;
`endif

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  gap      = 1;

  task automatic push(input int k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [15:0] v, input string name);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected pulse with value %h, no pulse required", name, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_fail++;
        $display("FAIL %s: got kind %0d value %h, required kind %0d value %h",
                 name, k, v, e.kind, e.val);
      end
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: pops one expected event per output pulse.
  always @(negedge clk) begin
    if (data_strobe) check_ev(EvData, {8'h00, data}, "data_strobe");
    if (frame_start) check_ev(EvStart, length, "frame_start");
    if (frame_done)  check_ev(EvDone, {15'h0, crc_ok}, "frame_done");
    if (error)       check_ev(EvErr, 16'h0, "error");
  end

  task automatic send_bit(input logic b);
    bit_strobe = 1'b1;
    bit_value  = b;
    @(posedge clk);
    #1;
    bit_strobe = 1'b0;
    bit_value  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic stuff);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
    send_bit(stuff);
  endtask

  task automatic send_pre(input int nz);
    repeat (nz) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  // "123456789", length 9, padded; first CRC word selectable to corrupt it.
  task automatic send_frame_body(input logic [15:0] crc_w0, input logic ok);
    push(EvStart, 16'd9);
    for (int i = 0; i < 9; i++) push(EvData, 16'h31 + 16'(i));
    push(EvDone, {15'h0, ok});
    send_word(16'h0900, 1'b1);
    send_word(16'h3132, 1'b1);
    send_word(16'h3334, 1'b1);
    send_word(16'h3536, 1'b1);
    send_word(16'h3738, 1'b1);
    send_word(16'h3900, 1'b1);
    send_word(crc_w0, 1'b1);
    send_word(16'hF4CB, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    bit_strobe = 1'b1;
    bit_value  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset      = 1'b0;
    bit_strobe = 1'b0;
    bit_value  = 1'b0;
    @(negedge clk);
    check_eq("reset_data", data, 0);
    check_eq("reset_length", length, 0);
    check_eq("reset_flags", {data_strobe, frame_start, frame_done, crc_ok, error}, 0);
    @(posedge clk);
    #1;

    // Test 1: good frame.
    send_pre(17);
    send_frame_body(16'h2639, 1'b1);
    drain("t1_drain");
    check_eq("t1_length_held", length, 16'd9);
    check_eq("t1_crc_ok_held", crc_ok, 1);

    // Test 2: corrupted CRC word.
    send_pre(17);
    send_frame_body(16'h2638, BadCrcOk);
    drain("t2_drain");
    check_eq("t2_crc_ok_held", crc_ok, BadCrcOk);

    // Test 3: short preamble is ignored, full one then locks.
    send_pre(16);
    drain("t3_short_pre");
    send_pre(17);
    send_frame_body(16'h2639, 1'b1);
    drain("t3_drain");

    // Test 4: bad stuff bit after first payload word; that zero seeds the next preamble.
    send_pre(17);
    push(EvStart, 16'd9);
    push(EvData, 16'h31);
    push(EvData, 16'h32);
    push(EvErr, 16'h0);
    send_word(16'h0900, 1'b1);
    send_word(16'h3132, 1'b0);
    drain("t4_error");
    send_pre(16);
    send_frame_body(16'h2639, 1'b1);
    drain("t4_drain");

    // Test 5: oversize length, then empty frame.
    send_pre(17);
    push(EvErr, 16'h0);
    send_word(16'h4100, 1'b1);
    drain("t5_oversize");
    send_pre(17);
    push(EvStart, 16'd0);
    push(EvDone, 16'd1);
    send_word(16'h0000, 1'b1);
    send_word(16'h0000, 1'b1);
    send_word(16'h0000, 1'b1);
    drain("t5_empty");
    check_eq("t5_length_zero", length, 0);

    // Test 6: reset mid-payload, then a back-to-back strobe frame.
    send_pre(17);
    push(EvStart, 16'd9);
    push(EvData, 16'h31);
    push(EvData, 16'h32);
    send_word(16'h0900, 1'b1);
    for (int i = 15; i >= 0; i--) send_bit(i == 15 ? 1'b0 : 1'b0 | (16'h3132 >> i) & 1'b1);
    repeat (2) @(posedge clk);
    drain("t6_partial");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_reset_length", length, 0);
    check_eq("t6_reset_data", data, 0);
    check_eq("t6_reset_flags", {data_strobe, frame_start, frame_done, crc_ok, error}, 0);
    @(posedge clk);
    #1;
    gap = 0;
    send_pre(17);
    send_frame_body(16'h2639, 1'b1);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
